// File: rtl/fsm_table_pkg.sv
// fsm_table_pkg: entry layout and width helpers shared by the table-driven Mealy FSM
package fsm_table_pkg;
  localparam int MAX_SW = 4;
  localparam int MAX_OW = 8;
  typedef struct packed {
    logic [MAX_SW-1:0] next_state;
    logic [MAX_OW-1:0] out;
  } entry_t;
  function automatic int sw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int aw_of(input int n, input int iw);
    return sw_of(n) + iw;
  endfunction
endpackage

// File: rtl/fsm_table_mem.sv
// fsm_table_mem: flop-based transition table, one write port, one asynchronous read port
module fsm_table_mem #(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter logic [DW-1:0] RST = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  // every entry returns to {start, 0} on reset; reset wins over a write
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < (1 << AW); i++) mem[i] <= RST;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fsm_table_mealy.sv
// fsm_table_mealy: programmable table-driven Mealy FSM with illegal-state recovery and transition counter
module fsm_table_mealy
  import fsm_table_pkg::*;
#(
  parameter int NUM_STATES  = 6,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 1,
  parameter int START_STATE = 0,
  parameter int REG_OUT     = 0,
  parameter int CNT_W       = 16,
  localparam int SW = sw_of(NUM_STATES),
  localparam int AW = aw_of(NUM_STATES, IN_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [IN_W-1:0]   x,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [SW+OUT_W-1:0] cfg_data,
  output logic [OUT_W-1:0]  z,
  output logic [SW-1:0]     state_o,
  output logic              err,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  trans_cnt
);
  localparam int DW = SW + OUT_W;
  localparam logic [SW:0] NS = (SW+1)'(NUM_STATES);
  localparam logic [SW-1:0] START = SW'(START_STATE);
  localparam logic [DW-1:0] RST_WORD = {START, {OUT_W{1'b0}}};
  logic [SW-1:0] state_q, state_d;
  logic err_q, err_d, cfg_err_q, illegal, bad_wr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] z_c, z_q;
  logic [DW-1:0] rd;
  entry_t ent;
  assign bad_wr = {1'b0, cfg_addr[AW-1:IN_W]} >= NS;
  fsm_table_mem #(.AW(AW), .DW(DW), .RST(RST_WORD)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we & ~bad_wr),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr ({state_q, x}),
    .rdata (rd)
  );
  assign ent = '{next_state: MAX_SW'(rd[DW-1:OUT_W]), out: MAX_OW'(rd[OUT_W-1:0])};
  assign illegal = {1'b0, ent.next_state} >= (MAX_SW+1)'(NUM_STATES);
  // state, error, counter, output and config-error registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= START;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      z_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      z_q       <= z_c;
      cfg_err_q <= cfg_we & bad_wr;
    end
  // next state: clr beats en; an out-of-range target falls back to start and flags err
  always_comb begin
    state_d = clr ? START : en ? (illegal ? START : SW'(ent.next_state)) : state_q;
    err_d   = clr ? 1'b0 : err_q | (en & illegal);
    cnt_d   = clr ? '0 : (en && state_d != state_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // Mealy output is only live while the FSM is actually stepping
  always_comb z_c = (en & ~clr) ? OUT_W'(ent.out) : '0;
  assign z         = (REG_OUT != 0) ? z_q : z_c;
  assign state_o   = state_q;
  assign err       = err_q;
  assign cfg_err   = cfg_err_q;
  assign trans_cnt = cnt_q;
endmodule

// File: doc/fsm_table_mealy.md
FSM_TABLE_MEALY -- requirements
Module: fsm_table_mealy

Interface
REQ-001 The block SHALL have parameter NUM_STATES, default 6, giving the number of legal states, with a range of 2..16.
REQ-002 The block SHALL have parameter IN_W, default 1, giving the input symbol width, with a range of 1..3.
REQ-003 The block SHALL have parameter OUT_W, default 1, giving the output symbol width, with a range of 1..8.
REQ-004 The block SHALL have parameter START_STATE, default 0, giving the state entered on reset, clear and illegal-state recovery.
REQ-005 The block SHALL have parameter REG_OUT, default 0: 0 gives a combinational Mealy output, 1 gives a registered output.
REQ-006 The block SHALL have parameter CNT_W, default 16, giving the width of the transition counter.
REQ-007 Derived widths: SW = clog2(NUM_STATES), minimum 1; AW = SW+IN_W.
REQ-008 The ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  en  in  1  advance the FSM this cycle
  clr  in  1  synchronous return to START_STATE
  x  in  IN_W  input symbol
  cfg_we  in  1  table write strobe
  cfg_addr  in  AW  {state, symbol} entry index
  cfg_data  in  SW+OUT_W  {next_state, out}
  z  out  OUT_W  Mealy output
  state_o  out  SW  current state
  err  out  1  sticky illegal-state flag
  cfg_err  out  1  one-cycle pulse for a write to an out-of-range entry
  trans_cnt  out  CNT_W  saturating count of state changes
REQ-009 One clock; reset is synchronous and active-high.

Function
REQ-010 The table SHALL hold NUM_STATES*2^IN_W entries, each an {next_state, out} pair, addressed as {state, x}.
REQ-011 With en=1 and clr=0, the state SHALL take the value table[{state,x}].next_state at the next clk edge.
REQ-012 With en=0 and clr=0, the state SHALL hold.
REQ-013 clr=1 SHALL force the state to START_STATE at the next edge, regardless of en; clr takes priority over en.
REQ-014 With REG_OUT=0: z SHALL equal table[{state,x}].out combinationally when en=1, and 0 when en=0 or clr=1.
REQ-015 With REG_OUT=1: z SHALL register the REQ-014 value, giving 1-cycle latency, and is 0 in the cycle after reset.
REQ-016 A cfg_we write SHALL update the entry at the next edge.
REQ-017 A lookup in the same cycle as a write to the same entry SHALL use the old contents.
REQ-018 A write with the cfg_addr state field >= NUM_STATES SHALL be ignored and SHALL pulse cfg_err for one cycle.
REQ-019 A write with cfg_data next_state >= NUM_STATES SHALL be stored unchanged; the block does not check it at write time.
REQ-020 When en=1 and the looked-up next_state >= NUM_STATES, the state SHALL go to START_STATE instead, and err SHALL set.
REQ-021 err SHALL stay set until reset or clr.
REQ-022 trans_cnt SHALL increment by 1 on each edge where en=1, clr=0 and the new state differs from the current state.
REQ-023 trans_cnt SHALL saturate at 2^CNT_W-1.
REQ-024 clr SHALL zero trans_cnt.
REQ-025 cfg writes and FSM operation SHALL proceed concurrently without stalling either.

Reset
REQ-026 On reset: state = START_STATE; z, err, cfg_err and trans_cnt = 0.
REQ-027 On reset, every table entry SHALL become {START_STATE, 0}.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge and override en, clr and cfg_we.

Structure
REQ-029 Package fsm_table_pkg SHALL hold the entry typedef and the width helper functions.
REQ-030 Sub-module fsm_table_mem SHALL hold the flop-based table, with one write port and one asynchronous read port.
REQ-031 The state register, error logic, counter and output stage SHALL be in fsm_table_mealy.

Verification
REQ-032 Program the defaults (6 states, IN_W=1) as:
  0:{x0->4/0, x1->3/1}, 1:{5/0, 3/0}, 2:{4/0, 1/1}, 3:{5/0, 1/0}, 4:{2/0, 5/1}, 5:{1/0, 2/0}.
  Drive x = 1,0,0,1 with en=1 from reset.
  Expect states 0->3->5->1->3, z = 1,0,0,0, and trans_cnt = 4.
REQ-033 Set REG_OUT=1 and repeat the REQ-032 sequence; z SHALL appear 1 cycle later with identical values.
REQ-034 Write entry {0,1} to next_state 7, then drive en=1, x=1 from state 0.
  Expect state 0 after the edge and err=1.
  Then assert clr; expect err=0.
REQ-035 Write cfg_addr state field 6.
  Expect cfg_err high for 1 cycle and no entry changed.
  Write {0,1} in the same cycle as a lookup of {0,1}; expect the old next_state to be used.
REQ-036 Assert en and clr together in state 3; expect state 0, trans_cnt 0 and z 0.
  Assert reset mid-sequence; expect all outputs 0 and the table cleared.
REQ-037 Set CNT_W=2 and run 5 state changes; expect trans_cnt to saturate at 3.
